// File: rtl/freq_divider.sv
// -----------------------------------------------------------------------------
// freq_divider
//
// Programmable integer clock divider. It produces new_clk, a divided version of
// clk, straight from a flop, so there is no combinational path from clk to the
// output. The ratio requested on div is sampled only at a period boundary
// (wrap). A period in progress therefore always finishes at its old ratio, and
// the output can never produce a runt pulse.
//
// For a steady ratio N the output is low for floor(N/2) cycles and then high
// for ceil(N/2) cycles, giving a period of exactly N clk cycles.
//
// Parameters
//   DIV_W        width of div and of the internal cycle counter
//   DEFAULT_DIV  ratio in force from reset until the first wrap (>= 2)
//
// Ports
//   clk      in   system clock, rising-edge active
//   reset    in   asynchronous active-low reset
//   div      in   requested ratio N (0 and 1 are treated as 2)
//   new_clk  out  divided clock, registered
// -----------------------------------------------------------------------------
module freq_divider #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   output logic             new_clk
);

   // Constants in counter width. An out-of-range DEFAULT_DIV is lifted to 2,
   // so the reset ratio can never produce a degenerate period.
   localparam logic [DIV_W-1:0] ZERO    = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
   localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV < 2) ? TWO : DIV_W'(DEFAULT_DIV);

   // State
   logic [DIV_W-1:0] cnt_r;      // position within the current period
   logic [DIV_W-1:0] act_div_r;  // ratio currently in force
   logic             new_clk_r;  // output flop

   // Next-state terms
   logic [DIV_W-1:0] eff_div_s;
   logic             wrap_s;
   logic [DIV_W-1:0] cnt_nxt_s;
   logic [DIV_W-1:0] act_div_nxt_s;
   logic [DIV_W-1:0] half_nxt_s;
   logic             new_clk_nxt_s;

   // Clamp the requested ratio so that 0 and 1 behave like 2.
   always_comb begin
      eff_div_s = div;
      if (div < TWO) begin
         eff_div_s = TWO;
      end else begin
         eff_div_s = div;
      end
   end

   // Period bookkeeping. The counter wraps and the ratio is reloaded only at
   // the last position of a period. The output level is then computed from the
   // *next* counter and ratio, so the flop presents the level that belongs to
   // the position the counter is moving into.
   always_comb begin
      wrap_s        = 1'b0;
      cnt_nxt_s     = cnt_r;
      act_div_nxt_s = act_div_r;
      half_nxt_s    = ZERO;
      new_clk_nxt_s = 1'b0;

      // act_div_r is always >= 2, so subtracting one cannot underflow.
      if (cnt_r == (act_div_r - ONE)) begin
         wrap_s        = 1'b1;
         cnt_nxt_s     = ZERO;
         act_div_nxt_s = eff_div_s;
      end else begin
         wrap_s        = 1'b0;
         cnt_nxt_s     = cnt_r + ONE;
         act_div_nxt_s = act_div_r;
      end

      // The low phase covers positions [0, floor(N/2)); the high phase covers
      // the rest, so an odd N gets the extra cycle in the high phase.
      half_nxt_s = act_div_nxt_s >> 1;
      if (cnt_nxt_s >= half_nxt_s) begin
         new_clk_nxt_s = 1'b1;
      end else begin
         new_clk_nxt_s = 1'b0;
      end
   end

   // State registers. Reset clears the output at once, independent of clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r     <= ZERO;
         act_div_r <= RST_DIV;
         new_clk_r <= 1'b0;
      end else begin
         cnt_r     <= cnt_nxt_s;
         act_div_r <= act_div_nxt_s;
         new_clk_r <= new_clk_nxt_s;
      end
   end

   assign new_clk = new_clk_r;

endmodule

// File: tb/tb_freq_divider.sv
// -----------------------------------------------------------------------------
// tb_freq_divider
//
// Self-checking bench for freq_divider. For each period it runs, the bench
// pushes the expected new_clk level at each position of that period into a
// scoreboard queue. The levels are low for floor(N/2) cycles, then high for
// the remaining cycles. On each falling clk edge it pops one entry and
// compares it with the DUT output. div is changed a known number of positions
// before the wrap, so the bench always knows which ratio the next period uses.
// -----------------------------------------------------------------------------
module tb_freq_divider;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] div;
   logic       new_clk;

   int err_cnt = 0;
   int chk_cnt = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   freq_divider #(
      .DIV_W      (8),
      .DEFAULT_DIV(2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .div    (div),
      .new_clk(new_clk)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_val(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
      chk_cnt++;
      if (actual !== expected) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Expected levels for one period of ratio n, position 0 first.
   task automatic push_period(input int n);
      for (int p = 0; p < n; p++) begin
         exp_q.push_back(p >= (n / 2));
      end
   endtask

   // Run one period of ratio n. At position chg_pos, div is set to next_div;
   // that value is the one loaded at the end of this period.
   task automatic run_period(input int n, input int next_div, input int chg_pos,
                             input string tag);
      logic [31:0] next_div_v;
      next_div_v = next_div;
      push_period(n);
      for (int p = 0; p < n; p++) begin
         @(negedge clk);
         check_val($sformatf("%s_p%0d", tag, p), {31'd0, new_clk},
                   {31'd0, exp_q.pop_front()});
         if (p == chg_pos) begin
            div = next_div_v[7:0];
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      div   = 8'd2;

      // Output held low while in reset.
      repeat (3) begin
         @(negedge clk);
         check_val("rst_hold", {31'd0, new_clk}, 32'd0);
      end
      @(posedge clk);
      #1 reset = 1'b1;

      // N=2 right after release: 0 (reset level), then 1,0,1,0...
      repeat (3) run_period(2, 2, 0, "n2");
      run_period(2, 4, 0, "n2_to4");

      // Even N=4: low 2 / high 2, three periods.
      repeat (3) run_period(4, 4, 0, "n4");
      run_period(4, 5, 0, "n4_to5");

      // Odd N=5: low 2 / high 3.
      repeat (2) run_period(5, 5, 0, "n5");
      run_period(5, 0, 0, "n5_to0");

      // Clamp: div=0 and div=1 behave like div=2.
      repeat (2) run_period(2, 0, 0, "clamp0");
      run_period(2, 1, 0, "clamp0_to1");
      repeat (2) run_period(2, 1, 0, "clamp1");
      run_period(2, 6, 0, "clamp1_to6");

      // Mid-period change: at div=6, switch to 3 at cnt=1.
      repeat (2) run_period(6, 6, 0, "n6");
      run_period(6, 3, 1, "n6_chg");
      repeat (3) run_period(3, 3, 0, "n3");
      run_period(3, 8, 0, "n3_to8");
      run_period(8, 8, 0, "n8");

      // Async reset mid-period while new_clk is high (positions 4..7).
      push_period(8);
      for (int p = 0; p < 6; p++) begin
         @(negedge clk);
         check_val($sformatf("n8_pre_rst_p%0d", p), {31'd0, new_clk},
                   {31'd0, exp_q.pop_front()});
      end
      #2 reset = 1'b0;
      #1 check_val("async_rst", {31'd0, new_clk}, 32'd0);
      exp_q.delete();
      repeat (2) begin
         @(negedge clk);
         check_val("rst_hold2", {31'd0, new_clk}, 32'd0);
      end
      @(posedge clk);
      #1 reset = 1'b1;

      // First period uses DEFAULT_DIV=2, then 8-cycle periods resume.
      run_period(2, 8, 0, "post_rst_def");
      repeat (2) run_period(8, 8, 0, "post_rst_n8");
      run_period(8, 255, 0, "n8_to255");

      // Maximum ratio.
      run_period(255, 255, 0, "n255");

      check_val("sb_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/freq_divider.md
Name: freq_divider

Overview:
- Programmable integer clock divider that produces a divided clock, new_clk, from the system clock clk.
- Used ahead of the VGA timing generator to derive the pixel clock (div = 2 gives a half-rate clock).
- The output comes straight from a flop: no combinational path from clk to new_clk, and no glitches when div changes.

Parameters:
- DIV_W, 8: width of the div port and of the internal cycle counter.
- DEFAULT_DIV, 2: division ratio used from reset until the first period boundary. Must be at least 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset. 0 forces the reset state immediately; release is sampled on clk.
- div  input  DIV_W  requested division ratio N. Values 0 and 1 are clamped to 2.
- new_clk  output  1  divided clock, registered.

Behaviour:
- Internal state:
  - cnt (DIV_W bits): position within the current period.
  - act_div (DIV_W bits): ratio currently in force.
  - new_clk flop.
- Reset (reset=0, asynchronous): cnt=0, act_div=DEFAULT_DIV, new_clk=0. All three are held while reset=0.
- Clamp rule: eff_div = 2 if div < 2, else div.
- Each rising clk edge with reset=1:
  - If cnt == act_div-1 (wrap): cnt <= 0 and act_div <= eff_div.
  - Otherwise: cnt <= cnt+1.
  - new_clk <= 1 if next cnt >= floor(next act_div / 2), else 0.
- Output waveform for a steady N:
  - period of exactly N clk cycles;
  - low for floor(N/2) cycles, then high for ceil(N/2) cycles.
  - Even N gives 50% duty; odd N has one extra high cycle.
- N=2: new_clk toggles on every clk edge. The first edge after reset release drives it to 1.
- div changes:
  - Sampled only at a wrap, so a period in progress always completes at its old ratio.
  - The new ratio takes effect from the next period.
  - new_clk never produces a pulse shorter than one clk cycle.
- Startup: the first period after reset uses DEFAULT_DIV. div is first loaded at the end of that period.
- Maximum ratio: 2^DIV_W - 1. All counter arithmetic is unsigned in DIV_W bits; cnt never exceeds act_div-1.
- Reset asserted mid-period: new_clk goes to 0 immediately, with no wait for a clk edge. The counter restarts from 0.
- No other outputs and no handshake. new_clk is meant to clock downstream logic directly.

Test Plan:
- Reset and N=2: hold reset=0 for 3 cycles with div=2, then release.
  - new_clk must be 0 during reset.
  - After release it must read 1,0,1,0,... on successive clk edges, i.e. a period of 2 cycles.
- Even N=4: new_clk repeats low 2 / high 2. Measure 3 consecutive periods; each must be 4 cycles.
- Odd N=5: new_clk repeats low 2 / high 3, with a period of 5 cycles.
- Clamp: div=0, then div=1. Both must yield the same toggle-every-edge waveform as div=2.
- Mid-period change: running at div=6, switch div to 3 at cnt=1.
  - The current period must finish at 6 cycles (low 3 / high 3).
  - The next periods must be 3 cycles (low 1 / high 2).
- Asynchronous reset: with div=8 and new_clk=1, assert reset=0 between clk edges.
  - new_clk must drop to 0 before the next clk edge.
  - After release, the first period follows DEFAULT_DIV=2.
  - 8-cycle periods must resume afterwards.
